// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests to block RAM or LED/switch/counter peripherals.
// Define MIO_COUNTER_EN to implement the free-running counter at 0xF000_0004.
module mio_bus_ctrl #(
  parameter int unsigned RAM_AW   = 14,
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_from_cpu,
  output logic [31:0]       Data_to_cpu,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic [31:0]       counter_out
);

  localparam logic [31:0] LED_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

  typedef enum logic [1:0] {S_IDLE, S_RAM_ACC, S_RAM_WAIT, S_DONE} state_t;

  state_t      state;
  logic        mem_w_q;
  logic [2:0]  wait_cnt;
  logic        accept;
  logic        is_ram;
  logic        is_led;
  logic        is_sw;
  logic        is_cnt;
  logic [31:0] periph_rd;

  assign accept    = (state == S_IDLE) && CPU_MIO;
  assign is_ram    = (Addr_in[31:16] == 16'h0000);
  assign is_led    = (Addr_in == LED_ADDR);
  assign is_sw     = (Addr_in == SW_ADDR);
  assign MIO_ready = ((state == S_IDLE) && !CPU_MIO) || (state == S_DONE);

`ifdef MIO_COUNTER_EN
  logic [31:0] counter;

  assign is_cnt      = (Addr_in == CNT_ADDR);
  assign counter_out = counter;

  // A CPU write on the accepting edge overrides that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (accept && mem_w && is_cnt) begin
      counter <= Data_from_cpu;
    end else begin
      counter <= counter + 32'd1;
    end
  end
`else
  assign is_cnt      = 1'b0;
  assign counter_out = '0;
`endif

  always_comb begin
    periph_rd = '0;
    if (is_led) begin
      periph_rd = {16'h0000, led};
    end else if (is_sw) begin
      periph_rd = {16'h0000, sw};
    end else if (is_cnt) begin
      periph_rd = counter_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_w_q     <= 1'b0;
      wait_cnt    <= '0;
      Data_to_cpu <= '0;
      led         <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CPU_MIO) begin
            mem_w_q <= mem_w;
            if (is_ram) begin
              // Address/data/we are registered here so the RAM sees them during RAM_ACC.
              ram_addr <= Addr_in[RAM_AW+1:2];
              ram_din  <= Data_from_cpu;
              ram_we   <= mem_w;
              state    <= S_RAM_ACC;
            end else begin
              if (mem_w) begin
                if (is_led) begin
                  led <= Data_from_cpu[15:0];
                end
              end else begin
                Data_to_cpu <= periph_rd;
              end
              state <= S_DONE;
            end
          end
        end
        S_RAM_ACC: begin
          ram_we <= 1'b0;
          if (RAM_WAIT == 0) begin
            if (!mem_w_q) begin
              Data_to_cpu <= ram_dout;
            end
            state <= S_DONE;
          end else begin
            wait_cnt <= 3'(RAM_WAIT - 1);
            state    <= S_RAM_WAIT;
          end
        end
        S_RAM_WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (!mem_w_q) begin
              Data_to_cpu <= ram_dout;
            end
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
